ic_fill_unit: RTL and testbench

Instruction-cache fill stage sitting directly downstream of the DDR interface's instruction path. It pops packed words from the DDR-to-instruction-cache FIFO (`{ins, rd_cnt, valid}`), unpacks them, and writes each valid instruction into the instruction-cache array at the index carried in the word. It counts words against the requested fill length, signals completion, and flags malformed or out-of-order data.

---
 rtl/ic_fill_unit.sv | 142 ++++++++++++++
 tb/tb_ic_fill_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_fill_unit.sv
// Instruction-cache fill stage: pops packed {ins, cnt, valid} words from the DDR
// instruction FIFO, writes valid instructions into the cache and tracks fill progress.
module ic_fill_unit #(
   parameter int ISA_WIDTH        = 30,
   parameter int ISA_DEPTH        = 72,
   parameter int CACHE_ADDR_WIDTH = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fill_req,
   input  logic [7:0]                  fill_len,
   input  logic [ISA_WIDTH+8:0]        fifo_dout,
   input  logic                        fifo_empty,
   output logic                        fifo_rd_en,
   output logic                        cache_wr_en,
   output logic [CACHE_ADDR_WIDTH-1:0] cache_wr_addr,
   output logic [ISA_WIDTH-1:0]        cache_wr_data,
   output logic                        fill_busy,
   output logic                        fill_done,
   output logic                        fill_err,
   output logic [1:0]                  fsm_state
);

   // Handshake: a pop is a one-cycle fifo_rd_en pulse; the popped word is on
   // fifo_dout exactly one cycle later, when rd_pending is high and it is consumed.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [8:0] DEPTH_LIMIT = 9'(ISA_DEPTH);

   state_t                        state, state_n;
   logic [7:0]                    len, len_n;
   logic [7:0]                    received, received_n;
   logic [7:0]                    expected, expected_n;
   logic                          rd_pending;
   logic                          err_n;
   logic                          done_n;
   logic                          wr_en_n;
   logic [CACHE_ADDR_WIDTH-1:0]   wr_addr_n;
   logic [ISA_WIDTH-1:0]          wr_data_n;

   logic                          w_valid;
   logic [7:0]                    w_cnt;
   logic [ISA_WIDTH-1:0]          w_ins;
   logic                          cnt_in_range;
   logic [8:0]                    in_flight;

   assign w_valid      = fifo_dout[0];
   assign w_cnt        = fifo_dout[8:1];
   assign w_ins        = fifo_dout[ISA_WIDTH+8:9];
   assign cnt_in_range = ({1'b0, w_cnt} < DEPTH_LIMIT);

   // Counting the word still in flight keeps us from popping words of the next fill.
   assign in_flight  = {1'b0, received} + {8'd0, rd_pending};
   assign fifo_rd_en = (state == FILL) && !fifo_empty && (in_flight < {1'b0, len});

   assign fill_busy = (state == FILL) || (state == DONE);
   assign fsm_state = state;

   always_comb begin
      state_n    = state;
      len_n      = len;
      received_n = received;
      expected_n = expected;
      err_n      = fill_err;
      done_n     = 1'b0;
      wr_en_n    = 1'b0;
      wr_addr_n  = cache_wr_addr;
      wr_data_n  = cache_wr_data;
      case (state)
         IDLE: begin
            if (fill_req) begin
               err_n = 1'b0;
               if (fill_len != 8'd0) begin
                  len_n      = fill_len;
                  received_n = 8'd0;
                  expected_n = 8'd0;
                  state_n    = FILL;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         FILL: begin
            if (rd_pending && w_valid) begin
               if (cnt_in_range) begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = w_cnt[CACHE_ADDR_WIDTH-1:0];
                  wr_data_n = w_ins;
               end
               if (!cnt_in_range || (w_cnt != expected)) begin
                  err_n = 1'b1;
               end
               // Out-of-range words still count so a bad stream cannot stall the fill.
               received_n = received + 8'd1;
               expected_n = expected + 8'd1;
               if (received_n == len) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         len           <= 8'd0;
         received      <= 8'd0;
         expected      <= 8'd0;
         rd_pending    <= 1'b0;
         fill_err      <= 1'b0;
         fill_done     <= 1'b0;
         cache_wr_en   <= 1'b0;
         cache_wr_addr <= '0;
         cache_wr_data <= '0;
      end else begin
         state         <= state_n;
         len           <= len_n;
         received      <= received_n;
         expected      <= expected_n;
         rd_pending    <= fifo_rd_en;
         fill_err      <= err_n;
         fill_done     <= done_n;
         cache_wr_en   <= wr_en_n;
         cache_wr_addr <= wr_addr_n;
         cache_wr_data <= wr_data_n;
      end
   end

endmodule

// File: tb/tb_ic_fill_unit.sv
// Randomised bench for ic_fill_unit: a FIFO model feeds the DUT, a queue-scanning
// reference predicts every cache write and fill outcome, a monitor checks them.
module tb_ic_fill_unit;

   localparam int IW    = 30;
   localparam int DEPTH = 72;
   localparam int AW    = 7;
   localparam int WW    = IW + 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          fill_req = 1'b0;
   logic [7:0]    fill_len = 8'd0;
   logic [WW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic          cache_wr_en;
   logic [AW-1:0] cache_wr_addr;
   logic [IW-1:0] cache_wr_data;
   logic          fill_busy;
   logic          fill_done;
   logic          fill_err;
   logic [1:0]    fsm_state;

   typedef struct {
      logic err;
      logic last_wr;
      int   pops;
      int   base;
   } done_rec_t;

   logic [WW-1:0]    fifo_q[$];
   logic [AW+IW-1:0] exp_q[$];
   done_rec_t        done_q[$];

   int   checks = 0;
   int   errors = 0;
   int   pop_total = 0;
   int   done_cnt = 0;
   int   wr_seen = 0;
   int   pcyc = 0;
   int   ncyc = 0;
   int   gap_mode = 0;
   int   done_pcyc = 0;
   logic pop_flag = 1'b0;

   done_rec_t        mon_d;
   logic [AW+IW-1:0] mon_e;

   ic_fill_unit #(.ISA_WIDTH(IW), .ISA_DEPTH(DEPTH), .CACHE_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .fill_req(fill_req), .fill_len(fill_len),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr),
      .cache_wr_data(cache_wr_data), .fill_busy(fill_busy), .fill_done(fill_done),
      .fill_err(fill_err), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pops are taken at the rising edge, exactly as a real FIFO would see them.
   always @(posedge clk) begin
      pcyc++;
      pop_flag = fifo_rd_en;
      if (fifo_rd_en) begin
         pop_total++;
         chk("pop_while_empty", 64'(fifo_empty), 64'(0));
      end
   end

   // FIFO model: present the popped word, then refresh the empty flag.
   always @(negedge clk) begin
      ncyc++;
      if (pop_flag) begin
         if (fifo_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_underflow: got pop expected no pop");
         end else begin
            fifo_dout = fifo_q.pop_front();
         end
      end
      fifo_empty = (fifo_q.size() == 0) || (gap_mode == 1 && (ncyc % 2 == 1)) ||
                   (gap_mode == 2 && $urandom_range(0, 2) == 0);
   end

   always @(negedge clk) begin
      if (cache_wr_en) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h expected none", cache_wr_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(cache_wr_addr), 64'(mon_e[AW+IW-1:IW]));
            chk("wr_data", 64'(cache_wr_data), 64'(mon_e[IW-1:0]));
         end
      end
      if (fill_done) begin
         done_cnt++;
         done_pcyc = pcyc;
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done expected none");
         end else begin
            mon_d = done_q.pop_front();
            chk("done_err", 64'(fill_err), 64'(mon_d.err));
            chk("done_with_last_write", 64'(cache_wr_en), 64'(mon_d.last_wr));
            chk("pop_count", 64'(pop_total - mon_d.base), 64'(mon_d.pops));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic push_word(input logic v, input logic [7:0] cnt, input logic [IW-1:0] ins);
      fifo_q.push_back({ins, cnt, v});
   endtask

   // Reference: walk the FIFO from its head until len valid words have been seen.
   task automatic model_fill(input logic [7:0] len);
      int            i = 0;
      int            nv = 0;
      logic [WW-1:0] w;
      logic [7:0]    c;
      done_rec_t     r;
      r.err = 1'b0;
      r.last_wr = 1'b0;
      while (nv < int'(len) && i < fifo_q.size()) begin
         w = fifo_q[i];
         if (w[0]) begin
            c = w[8:1];
            if (int'(c) < DEPTH) exp_q.push_back({c[AW-1:0], w[WW-1:9]});
            r.last_wr = (int'(c) < DEPTH);
            if (int'(c) >= DEPTH || int'(c) != nv) r.err = 1'b1;
            nv++;
         end
         i++;
      end
      r.pops = i;
      r.base = pop_total;
      done_q.push_back(r);
   endtask

   task automatic start_fill(input logic [7:0] len);
      model_fill(len);
      fill_req = 1'b1;
      fill_len = len;
      step();
      fill_req = 1'b0;
      chk("busy_after_req", 64'(fill_busy), 64'(len != 8'd0));
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 400) begin
         step();
         n++;
      end
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no fill_done expected one within 400 cycles");
      end
      step();
      chk("busy_after_done", 64'(fill_busy), 64'(0));
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'(0));
      chk({tag, "_wr_en"}, 64'(cache_wr_en), 64'(0));
      chk({tag, "_wr_addr"}, 64'(cache_wr_addr), 64'(0));
      chk({tag, "_wr_data"}, 64'(cache_wr_data), 64'(0));
      chk({tag, "_busy"}, 64'(fill_busy), 64'(0));
      chk({tag, "_done"}, 64'(fill_done), 64'(0));
      chk({tag, "_err"}, 64'(fill_err), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w0, start_pcyc, n, len, nv, idx, r;
      logic [7:0] c;

      step(3);
      check_outputs_zero("reset");
      rst = 1'b1;
      step(2);

      // Nominal four-word fill with back-to-back writes.
      for (int i = 0; i < 4; i++) push_word(1'b1, 8'(i), IW'(32'h1000 + i));
      d0 = done_cnt;
      start_pcyc = pcyc;
      start_fill(8'd4);
      wait_done(d0);
      chk("nominal_latency", 64'(done_pcyc - start_pcyc), 64'(6));

      // Discard one word and leave the next fill's word untouched.
      push_word(1'b1, 8'd0, IW'(32'h2000));
      push_word(1'b0, 8'd9, IW'(32'h2fff));
      push_word(1'b1, 8'd1, IW'(32'h2001));
      push_word(1'b1, 8'd2, IW'(32'h2002));
      push_word(1'b1, 8'd3, IW'(32'h2003));
      d0 = done_cnt;
      start_fill(8'd3);
      wait_done(d0);
      chk("leftover_size", 64'(fifo_q.size()), 64'(1));
      if (fifo_q.size() > 0) chk("leftover_word", 64'(fifo_q[0]), 64'({IW'(32'h2003), 8'd3, 1'b1}));
      fifo_q.delete();

      // Out-of-order index, then an out-of-range index.
      push_word(1'b1, 8'd0, IW'(32'h3000));
      push_word(1'b1, 8'd2, IW'(32'h3002));
      d0 = done_cnt;
      start_fill(8'd2);
      wait_done(d0);
      push_word(1'b1, 8'd80, IW'(32'h3080));
      d0 = done_cnt;
      start_fill(8'd1);
      wait_done(d0);

      // FIFO empty every other cycle.
      for (int i = 0; i < 8; i++) push_word(1'b1, 8'(i), IW'(32'h4000 + i));
      gap_mode = 1;
      d0 = done_cnt;
      start_fill(8'd8);
      wait_done(d0);
      step(3);
      chk("single_done", 64'(done_cnt - d0), 64'(1));
      gap_mode = 0;

      // Zero length completes at once and leaves the FIFO alone.
      push_word(1'b1, 8'd0, IW'(32'h5000));
      d0 = done_cnt;
      start_fill(8'd0);
      wait_done(d0);
      chk("zero_len_fifo", 64'(fifo_q.size()), 64'(1));
      fifo_q.delete();

      // A request during a fill must not change its length.
      for (int i = 0; i < 8; i++) push_word(1'b1, 8'(i), IW'(32'h6000 + i));
      d0 = done_cnt;
      start_fill(8'd5);
      step(2);
      fill_req = 1'b1;
      fill_len = 8'd2;
      step();
      fill_req = 1'b0;
      wait_done(d0);
      chk("ignored_req_leftover", 64'(fifo_q.size()), 64'(3));
      fifo_q.delete();

      // Reset in the middle of a six-word fill.
      for (int i = 0; i < 10; i++) push_word(1'b1, 8'(i), IW'(32'h7000 + i));
      w0 = wr_seen;
      start_fill(8'd6);
      n = 0;
      while (wr_seen - w0 < 2 && n < 100) begin
         step();
         n++;
      end
      chk("writes_before_reset", 64'(wr_seen - w0), 64'(2));
      rst = 1'b0;
      #1;
      check_outputs_zero("midfill_reset");
      exp_q.delete();
      done_q.delete();
      step(2);
      rst = 1'b1;
      step();
      d0 = done_cnt;
      start_fill(8'd4);
      wait_done(d0);
      fifo_q.delete();

      // Randomised fills with discards, bad indices and FIFO gaps.
      for (int f = 0; f < 14; f++) begin
         len = $urandom_range(1, 12);
         nv = 0;
         idx = 0;
         while (nv < len + 2) begin
            if ($urandom_range(0, 4) == 0) begin
               push_word(1'b0, 8'($urandom), IW'($urandom));
            end else begin
               r = $urandom_range(0, 9);
               if (r == 0) c = 8'($urandom_range(DEPTH, 255));
               else if (r == 1) c = 8'(idx + 1);
               else c = 8'(idx);
               push_word(1'b1, c, IW'($urandom));
               idx++;
               nv++;
            end
         end
         gap_mode = $urandom_range(0, 2);
         d0 = done_cnt;
         start_fill(8'(len));
         wait_done(d0);
         gap_mode = 0;
         step();
         fifo_q.delete();
      end

      step(3);
      chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
      chk("done_q_drained", 64'(done_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
